// File: rtl/pc_gen.sv
// Fetch PC generator with single-entry redirect buffer for a delayed-branch pipeline.
// Optional misaligned-fetch detection is enabled by defining PC_ALIGN_CHECK_EN.
module pc_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        cmp_out,
  input  logic [2:0]  npc_op,
  input  logic [31:0] d_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] rs_val,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic        redirect_pend,
  output logic        exc_adel
);

  localparam int unsigned XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_3000;

  localparam logic [2:0] OP_SEQ = 3'b000;
  localparam logic [2:0] OP_BR  = 3'b001;
  localparam logic [2:0] OP_J   = 3'b010;
  localparam logic [2:0] OP_JR  = 3'b011;

  typedef enum logic {IDLE, PEND} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic [XLEN-1:0] d_pc_plus4;
  logic [XLEN-1:0] br_offset;
  logic [XLEN-1:0] target;
  logic            redirect;
  logic            advance;

  // Target selection from the instruction currently in D.
  always_comb begin
    d_pc_plus4 = d_pc + XLEN'(4);
    br_offset  = {{14{imm16[15]}}, imm16, 2'b00};
    case (npc_op)
      OP_BR:   target = d_pc_plus4 + br_offset;
      OP_J:    target = {d_pc_plus4[31:28], index26, 2'b00};
      OP_JR:   target = rs_val;
      default: target = d_pc_plus4;
    endcase
  end

  assign advance  = !stall && imem_ready;
  assign redirect = (state_q == IDLE) && !stall &&
                    (((npc_op == OP_BR) && cmp_out) || (npc_op == OP_J) || (npc_op == OP_JR));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pc            <= RESET_PC;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc            <= pc_d;
      pend_target_q <= pend_target_d;
    end
  end

  // Next-state: a redirect that misses the fetch handshake parks its target in PEND.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc;
    pend_target_d = pend_target_q;
    if (!stall) begin
      case (state_q)
        IDLE: begin
          if (redirect) begin
            if (imem_ready) begin
              pc_d = target;
            end else begin
              pend_target_d = target;
              state_d       = PEND;
            end
          end else if (advance) begin
            pc_d = pc + XLEN'(4);
          end
        end
        PEND: begin
          if (imem_ready) begin
            pc_d    = pend_target_q;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign redirect_pend = (state_q == PEND);

`ifdef PC_ALIGN_CHECK_EN
  assign exc_adel = (pc[1:0] != 2'b00);
  assign imem_req = reset && !exc_adel;
`else
  assign exc_adel = 1'b0;
  assign imem_req = reset;
`endif

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 The module SHALL have the port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port: reset  in  1  asynchronous, active-low reset.
REQ-003 The module SHALL have the port: stall  in  1  hazard-unit freeze of the F/D stages.
REQ-004 The module SHALL have the port: imem_ready  in  1  instruction memory delivers the word at pc this cycle.
REQ-005 The module SHALL have the port: cmp_out  in  1  branch condition from the D-stage comparator (1 = taken).
REQ-006 The module SHALL have the port: npc_op  in  3  000 sequential, 001 conditional branch, 010 j/jal, 011 jr; 100-111 reserved.
REQ-007 The module SHALL have the port: d_pc  in  32  PC of the instruction in D.
REQ-008 The module SHALL have the port: imm16  in  16  branch offset.
REQ-009 The module SHALL have the port: index26  in  26  jump index.
REQ-010 The module SHALL have the port: rs_val  in  32  forwarded rs value for jr.
REQ-011 The module SHALL have the port: pc  out  32  fetch address (registered).
REQ-012 The module SHALL have the port: imem_req  out  1  fetch request.
REQ-013 The module SHALL have the port: redirect_pend  out  1  1 while in state PEND.
REQ-014 The module SHALL have the port: exc_adel  out  1  misaligned-fetch flag (see Configuration).

Function
REQ-015 advance SHALL be defined as (stall==0 && imem_ready==1); pc SHALL change only on a rising clk edge where advance==1.
REQ-016 redirect SHALL be defined as (npc_op==001 && cmp_out) || npc_op==010 || npc_op==011, sampled only in state IDLE with stall==0.
REQ-017 Branch target SHALL be d_pc + 4 + (sign-extended imm16 << 2), computed modulo 2^32 with wrap-around and no overflow flag.
REQ-018 Jump target SHALL be {(d_pc+4)[31:28], index26, 2'b00}; jr target SHALL be rs_val unmodified.
REQ-019 npc_op==001 with cmp_out==0, npc_op==000, and npc_op 100-111 SHALL all yield pc+4.
REQ-020 The state machine SHALL have two states, IDLE and PEND.
REQ-021 In IDLE with redirect and advance, pc SHALL load the target on the next edge and the state SHALL remain IDLE.
REQ-022 In IDLE with redirect, stall==0 and imem_ready==0, the target SHALL be latched into pend_target, pc SHALL hold (delay slot still being fetched), and the state SHALL go to PEND.
REQ-023 In IDLE without redirect and with advance, pc SHALL load pc+4.
REQ-024 In PEND, npc_op, cmp_out, d_pc, imm16, index26 and rs_val SHALL be ignored; on advance, pc SHALL load pend_target and the state SHALL return to IDLE.
REQ-025 When stall==1, pc, state and pend_target SHALL hold regardless of every other input, including imem_ready.
REQ-026 redirect_pend SHALL equal 1 exactly while in PEND.
REQ-027 imem_req SHALL be 1 whenever reset is deasserted, except as stated in REQ-034.
REQ-028 Redirect latency SHALL be one edge from the cycle the D-stage inputs are accepted; there SHALL be exactly one delay-slot fetch (the word at the current pc) between the branch and its target.

Reset
REQ-029 Asserting reset (reset==0) SHALL immediately, without waiting for clk, set pc=0x0000_3000, state=IDLE, pend_target=0, redirect_pend=0, imem_req=0 and exc_adel=0.
REQ-030 A reset asserted while in PEND SHALL discard the pending target.
REQ-031 After reset deasserts, the first rising edge SHALL evaluate normally from pc=0x0000_3000.

Configuration
REQ-032 The block SHALL support exactly one compile-time option, controlled by the macro PC_ALIGN_CHECK_EN.
REQ-033 With PC_ALIGN_CHECK_EN defined, exc_adel SHALL equal (pc[1:0]!=0) combinationally; a misaligned jr target SHALL still be loaded into pc.
REQ-034 With PC_ALIGN_CHECK_EN defined, imem_req SHALL be 0 while exc_adel==1.
REQ-035 Without PC_ALIGN_CHECK_EN, exc_adel SHALL be constant 0 and no alignment logic SHALL be synthesised.

Verification
REQ-036 Reset, then release with imem_ready=1, stall=0, npc_op=000 for 3 edges -> pc = 0x3000, 0x3004, 0x3008, 0x300C.
REQ-037 d_pc=0x3008, npc_op=001, cmp_out=1, imm16=0xFFFE, advance -> next pc=0x3004; the same with cmp_out=0 -> pc+4.
REQ-038 npc_op=010, d_pc=0x3010, index26=0x0000C40, then npc_op=011, rs_val=0x0000_4000 -> pc=0x0000_3100, then pc=0x0000_4000.
REQ-039 A redirect to 0x3100 with imem_ready=0 -> redirect_pend=1, pc holds; changing npc_op to 011 has no effect; on imem_ready=1 -> pc=0x3100, redirect_pend=0.
REQ-040 stall=1 for 4 edges while in PEND -> pc and redirect_pend unchanged; assert reset mid-PEND -> pc=0x3000 immediately, redirect_pend=0.
REQ-041 With PC_ALIGN_CHECK_EN defined, jr to 0x0000_4002 -> pc=0x4002, exc_adel=1, imem_req=0; without the macro, exc_adel=0 and imem_req=1.
